// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, sample rate, enable reporting,
// with resend/retry/timeout handling and hot-plug detection while streaming.
module ps2_mouse_init_sequencer #(
  parameter logic [23:0] POWERUP_DELAY    = 24'd500000,
  parameter logic [23:0] RESPONSE_TIMEOUT = 24'd2000000,
  parameter logic [27:0] BAT_TIMEOUT      = 28'd100000000,
  parameter logic [2:0]  MAX_RETRIES      = 3'd3,
  parameter logic [7:0]  SAMPLE_RATE      = 8'd200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       restart,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       stream_enable,
  output logic       init_done,
  output logic       init_fail,
  output logic [2:0] retry_count
);

  typedef enum logic [2:0] {
    S_POWERUP, S_SEND, S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID, S_STREAM, S_FAIL
  } state_t;

  state_t      r_state;
  logic [27:0] r_timer;
  logic [1:0]  r_idx;
  logic [1:0]  r_pos;
  logic        r_aa_seen;
  logic [7:0]  r_tx_byte;
  logic        r_tx_valid;
  logic        r_stream_enable;
  logic        r_init_done;
  logic        r_init_fail;
  logic [2:0]  r_retry_count;

  logic        w_wait;
  logic        w_rx_good;
  logic        w_tmo;
  logic [7:0]  w_expect;
  logic        w_ok;
  logic        w_resend;
  logic        w_fail;
  logic [2:0]  w_retry_next;

  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cmd_byte = 8'hFF;
      2'd1:    cmd_byte = 8'hF3;
      2'd2:    cmd_byte = SAMPLE_RATE;
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  assign w_wait       = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_BAT) || (r_state == S_WAIT_ID);
  assign w_rx_good    = rx_valid && !rx_error;
  assign w_tmo        = (r_timer == 28'd0);
  assign w_retry_next = (r_retry_count >= MAX_RETRIES) ? MAX_RETRIES : r_retry_count + 3'd1;

  always_comb begin
    w_expect = 8'hFA;
    case (r_state)
      S_WAIT_BAT: w_expect = 8'hAA;
      S_WAIT_ID:  w_expect = 8'h00;
      default:    w_expect = 8'hFA;
    endcase
  end

  assign w_ok     = w_rx_good && (rx_byte == w_expect);
  assign w_resend = (r_state == S_WAIT_ACK) && w_rx_good && (rx_byte == 8'hFE);
  // A coincident rx_error discards the byte; a timeout only counts when no byte arrives.
  assign w_fail   = w_wait && (rx_error || (w_rx_good && !w_ok && !w_resend) || (!rx_valid && w_tmo));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_POWERUP;
      r_timer         <= {4'd0, POWERUP_DELAY};
      r_idx           <= 2'd0;
      r_pos           <= 2'd0;
      r_aa_seen       <= 1'b0;
      r_tx_byte       <= 8'h00;
      r_tx_valid      <= 1'b0;
      r_stream_enable <= 1'b0;
      r_init_done     <= 1'b0;
      r_init_fail     <= 1'b0;
      r_retry_count   <= 3'd0;
    end else if (restart) begin
      r_state         <= S_POWERUP;
      r_timer         <= {4'd0, POWERUP_DELAY};
      r_idx           <= 2'd0;
      r_pos           <= 2'd0;
      r_aa_seen       <= 1'b0;
      r_tx_valid      <= 1'b0;
      r_stream_enable <= 1'b0;
      r_init_done     <= 1'b0;
      r_init_fail     <= 1'b0;
      r_retry_count   <= 3'd0;
    end else begin
      case (r_state)
        S_POWERUP: begin
          if (w_tmo) begin
            r_state <= S_SEND;
            r_idx   <= 2'd0;
          end else begin
            r_timer <= r_timer - 28'd1;
          end
        end
        S_SEND: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= cmd_byte(r_idx);
          end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_WAIT_ACK;
            r_timer    <= {4'd0, RESPONSE_TIMEOUT};
          end
        end
        S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID: begin
          if (w_fail) begin
            r_retry_count <= w_retry_next;
            if (w_retry_next == MAX_RETRIES) begin
              r_state     <= S_FAIL;
              r_init_fail <= 1'b1;
              r_tx_byte   <= 8'h00;
            end else begin
              r_state <= S_SEND;
              r_idx   <= 2'd0;
            end
          end else if (w_resend) begin
            r_retry_count <= w_retry_next;
            r_state       <= S_SEND;
          end else if (w_ok) begin
            if (r_state == S_WAIT_BAT) begin
              r_state <= S_WAIT_ID;
              r_timer <= {4'd0, RESPONSE_TIMEOUT};
            end else if (r_state == S_WAIT_ID) begin
              r_state <= S_SEND;
              r_idx   <= 2'd1;
            end else if (r_idx == 2'd0) begin
              r_state <= S_WAIT_BAT;
              r_timer <= BAT_TIMEOUT;
            end else if (r_idx == 2'd3) begin
              r_state         <= S_STREAM;
              r_stream_enable <= 1'b1;
              r_init_done     <= 1'b1;
              r_timer         <= {4'd0, RESPONSE_TIMEOUT};
              r_pos           <= 2'd0;
              r_aa_seen       <= 1'b0;
            end else begin
              r_state <= S_SEND;
              r_idx   <= r_idx + 2'd1;
            end
          end else begin
            r_timer <= r_timer - 28'd1;
          end
        end
        S_STREAM: begin
          if (rx_error) begin
            r_pos     <= 2'd0;
            r_aa_seen <= 1'b0;
            r_timer   <= {4'd0, RESPONSE_TIMEOUT};
          end else if (rx_valid) begin
            r_timer <= {4'd0, RESPONSE_TIMEOUT};
            // AA then 00 at packet start is a freshly plugged device finishing its BAT.
            if ((r_pos == 2'd1) && r_aa_seen && (rx_byte == 8'h00)) begin
              r_state         <= S_SEND;
              r_idx           <= 2'd1;
              r_stream_enable <= 1'b0;
              r_init_done     <= 1'b0;
              r_retry_count   <= 3'd0;
              r_pos           <= 2'd0;
              r_aa_seen       <= 1'b0;
            end else begin
              r_pos     <= (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;
              r_aa_seen <= (r_pos == 2'd0) && (rx_byte == 8'hAA);
            end
          end else if (w_tmo) begin
            r_pos     <= 2'd0;
            r_aa_seen <= 1'b0;
            r_timer   <= {4'd0, RESPONSE_TIMEOUT};
          end else begin
            r_timer <= r_timer - 28'd1;
          end
        end
        S_FAIL: begin
          r_tx_valid <= 1'b0;
        end
        default: begin
          r_state <= S_POWERUP;
          r_timer <= {4'd0, POWERUP_DELAY};
        end
      endcase
    end
  end

  assign tx_byte       = r_tx_byte;
  assign tx_valid      = r_tx_valid;
  assign stream_enable = r_stream_enable;
  assign init_done     = r_init_done;
  assign init_fail     = r_init_fail;
  assign retry_count   = r_retry_count;

endmodule
